// File: rtl/mem_rd_resp_pkg.sv
// mem_rd_resp_pkg: load func3 codes, responder FSM states and doubleword alignment helpers
package mem_rd_resp_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [63:0] DW_MASK = ~64'h7;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    function automatic logic load_bad(input logic [2:0] f3, input logic [2:0] off);
        return (f3 == 3'b111)
            || ((f3 == F3_LH || f3 == F3_LHU) && off[0])
            || ((f3 == F3_LW || f3 == F3_LWU) && off[1:0] != 2'b00)
            || (f3 == F3_LD && off != 3'b000);
    endfunction
endpackage

// File: rtl/mem_rd_resp_align.sv
// load_align: selects the addressed byte/half/word/double of a doubleword and sign- or zero-extends it
module load_align (
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  func3,
    output logic [63:0] data
);
    logic [63:0] sh;
    logic        sx;
    always_comb begin
        sh   = rdata >> {off, 3'b000};
        sx   = !func3[2];
        data = func3[1:0] == 2'b00 ? {{56{sx & sh[7]}}, sh[7:0]} :
               func3[1:0] == 2'b01 ? {{48{sx & sh[15]}}, sh[15:0]} :
               func3[1:0] == 2'b10 ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
    end
endmodule

// File: rtl/mem_rd_resp.sv
// mem_rd_resp: single-outstanding load responder issuing one aligned SRAM read per request
module mem_rd_resp
    import mem_rd_resp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [2:0]        req_func3_i,
    input  logic [4:0]        req_rd_i,
    output logic              sram_ren_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic              sram_rvalid_i,
    input  logic [63:0]       sram_rdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [63:0]       resp_data_o,
    output logic [4:0]        resp_rd_o,
    output logic              resp_err_o
);
    state_t            state, nxt;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        func3;
    logic [4:0]        rd;
    logic [15:0]       cnt;
    logic [63:0]       data, ext;
    logic              err, accept, bad, timeout;

    assign accept       = req_valid_i & req_ready_o;
    assign bad          = load_bad(req_func3_i, req_addr_i[2:0]);
    assign timeout      = cnt == 16'(TIMEOUT_CYCLES - 1);
    assign req_ready_o  = rst_n && state == IDLE;
    assign sram_ren_o   = state == ISSUE;
    assign sram_addr_o  = sram_ren_o ? addr & ADDR_W'(DW_MASK) : '0;
    assign resp_valid_o = state == RESP;
    assign resp_data_o  = data;
    assign resp_rd_o    = rd;
    assign resp_err_o   = err;

    load_align u_align (.rdata(sram_rdata_i), .off(addr[2:0]), .func3(func3), .data(ext));

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? (bad ? RESP : ISSUE) : IDLE;
            ISSUE:   nxt = WAIT;
            WAIT:    nxt = (sram_rvalid_i || timeout) ? RESP : WAIT;
            RESP:    nxt = resp_ready_i ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // data/err are rewritten every WAIT cycle; only the value on the exit cycle reaches RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            func3 <= '0;
            rd    <= '0;
            cnt   <= '0;
            data  <= '0;
            err   <= 1'b0;
        end else begin
            if (accept) begin
                addr  <= req_addr_i;
                func3 <= req_func3_i;
                rd    <= req_rd_i;
                data  <= '0;
                err   <= bad;
            end
            if (state == ISSUE) cnt <= '0;
            if (state == WAIT) begin
                cnt  <= cnt + 16'd1;
                data <= sram_rvalid_i ? ext : '0;
                err  <= !sram_rvalid_i;
            end
        end
    end
endmodule

// File: tb/tb_mem_rd_resp.sv
// tb_mem_rd_resp: directed self-checking bench for the load read responder
module tb_mem_rd_resp;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_ready;
    logic [63:0] req_addr = '0;
    logic [2:0]  req_func3 = '0;
    logic [4:0]  req_rd = '0;
    logic        sram_ren;
    logic [63:0] sram_addr;
    logic        sram_rvalid = 0;
    logic [63:0] sram_rdata = '0;
    logic        resp_valid, resp_ready = 0, resp_err;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    int errors = 0, checks = 0;

    mem_rd_resp #(.TIMEOUT_CYCLES(4), .ADDR_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_func3_i(req_func3), .req_rd_i(req_rd),
        .sram_ren_o(sram_ren), .sram_addr_o(sram_addr),
        .sram_rvalid_i(sram_rvalid), .sram_rdata_i(sram_rdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_rd_o(resp_rd), .resp_err_o(resp_err)
    );

    always #5 clk = ~clk;

    // called at a negedge with the DUT idle; returns at the negedge of cycle 1
    task automatic send(input logic [63:0] a, input logic [2:0] f, input logic [4:0] r);
        req_valid = 1; req_addr = a; req_func3 = f; req_rd = r;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic handshake();
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({req_ready, sram_ren, sram_addr, resp_valid, resp_data, resp_rd, resp_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b ren=%b addr=%h valid=%b data=%h rd=%0d err=%b, expected all 0",
                     req_ready, sram_ren, sram_addr, resp_valid, resp_data, resp_rd, resp_err);
        end
        rst_n = 1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        @(negedge clk);
    endtask

    task automatic test_ld();
        send(64'h8000_0008, 3'b011, 5'd5);
        checks++;
        if (sram_ren !== 1'b1 || sram_addr !== 64'h8000_0008) begin
            errors++; $display("FAIL ld_strobe: ren=%b addr=%h expected 1 / 80000008", sram_ren, sram_addr);
        end
        @(negedge clk);
        sram_rvalid = 1; sram_rdata = 64'h1122_3344_5566_7788;
        checks++;
        if (sram_ren !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL ld_cycle2: ren=%b valid=%b expected 0 0", sram_ren, resp_valid);
        end
        @(negedge clk);
        sram_rvalid = 0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'h1122_3344_5566_7788 || resp_rd !== 5'd5 || resp_err !== 1'b0) begin
            errors++; $display("FAIL ld_resp: valid=%b data=%h rd=%0d err=%b expected 1 1122334455667788 5 0",
                               resp_valid, resp_data, resp_rd, resp_err);
        end
        handshake();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL ld_idle: valid=%b ready=%b expected 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_extend();
        logic [63:0] a [6] = '{64'h8000_0003, 64'h8000_0003, 64'h8000_0002, 64'h8000_0000, 64'h8000_0002, 64'h8000_0001};
        logic [2:0]  f [6] = '{3'b000, 3'b100, 3'b001, 3'b110, 3'b101, 3'b000};
        logic [63:0] e [6] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_FFFF_80FF,
                               64'h80FF_7F00, 64'h80FF, 64'h7F};
        for (int i = 0; i < 6; i++) begin
            send(a[i], f[i], 5'(i + 10));
            @(negedge clk);
            sram_rvalid = 1; sram_rdata = 64'h0000_0000_80FF_7F00;
            @(negedge clk);
            sram_rvalid = 0;
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== e[i] || resp_err !== 1'b0 || resp_rd !== 5'(i + 10)) begin
                errors++; $display("FAIL extend_%0d: valid=%b data=%h err=%b rd=%0d expected 1 %h 0 %0d",
                                   i, resp_valid, resp_data, resp_err, resp_rd, e[i], i + 10);
            end
            handshake();
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] a [4] = '{64'h8000_0006, 64'h8000_0000, 64'h8000_0001, 64'h8000_0004};
        logic [2:0]  f [4] = '{3'b010, 3'b111, 3'b001, 3'b011};
        for (int i = 0; i < 4; i++) begin
            send(a[i], f[i], 5'd7);
            checks++;
            if (sram_ren !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 64'h0 || resp_rd !== 5'd7) begin
                errors++; $display("FAIL misaligned_%0d: ren=%b valid=%b err=%b data=%h rd=%0d expected 0 1 1 0 7",
                                   i, sram_ren, resp_valid, resp_err, resp_data, resp_rd);
            end
            handshake();
        end
    endtask

    task automatic test_timeout();
        send(64'h8000_0010, 3'b011, 5'd9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL timeout_wait_%0d: valid=%b expected 0", i, resp_valid); end
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 64'h0 || resp_rd !== 5'd9) begin
            errors++; $display("FAIL timeout_resp: valid=%b err=%b data=%h rd=%0d expected 1 1 0 9",
                               resp_valid, resp_err, resp_data, resp_rd);
        end
        handshake();
        sram_rvalid = 1; sram_rdata = 64'hDEAD;
        @(negedge clk);
        sram_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL timeout_late_%0d: valid=%b ready=%b expected 0 1", i, resp_valid, req_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        send(64'h8000_0008, 3'b011, 5'd4);
        @(negedge clk);
        sram_rvalid = 1; sram_rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        sram_rvalid = 0;
        req_valid = 1; req_addr = 64'h8000_0003; req_func3 = 3'b100; req_rd = 5'd12;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 64'h0123_4567_89AB_CDEF || resp_rd !== 5'd4 ||
                resp_err !== 1'b0 || req_ready !== 1'b0 || sram_ren !== 1'b0) begin
                errors++; $display("FAIL hold_%0d: valid=%b data=%h rd=%0d err=%b ready=%b ren=%b expected 1 0123456789abcdef 4 0 0 0",
                                   i, resp_valid, resp_data, resp_rd, resp_err, req_ready, sram_ren);
            end
        end
        handshake();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || sram_ren !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: valid=%b ready=%b ren=%b expected 0 1 0", resp_valid, req_ready, sram_ren);
        end
        @(negedge clk);
        req_valid = 0;
        checks++;
        if (sram_ren !== 1'b1 || sram_addr !== 64'h8000_0000) begin
            errors++; $display("FAIL b2b_issue: ren=%b addr=%h expected 1 80000000", sram_ren, sram_addr);
        end
        @(negedge clk);
        sram_rvalid = 1; sram_rdata = 64'h0000_0000_80FF_7F00;
        @(negedge clk);
        sram_rvalid = 0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'h80 || resp_rd !== 5'd12) begin
            errors++; $display("FAIL b2b_resp: valid=%b data=%h rd=%0d expected 1 80 12", resp_valid, resp_data, resp_rd);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        send(64'h8000_0008, 3'b011, 5'd6);
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if ({req_ready, sram_ren, sram_addr, resp_valid, resp_data, resp_rd, resp_err} !== '0) begin
            errors++; $display("FAIL midreset_outputs: ready=%b ren=%b addr=%h valid=%b data=%h rd=%0d err=%b expected all 0",
                               req_ready, sram_ren, sram_addr, resp_valid, resp_data, resp_rd, resp_err);
        end
        @(negedge clk);
        rst_n = 1;
        sram_rvalid = 1; sram_rdata = 64'h5555;
        @(negedge clk);
        sram_rvalid = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || sram_ren !== 1'b0) begin
                errors++; $display("FAIL midreset_idle_%0d: valid=%b ready=%b ren=%b expected 0 1 0", i, resp_valid, req_ready, sram_ren);
            end
            @(negedge clk);
        end
        send(64'h8000_0004, 3'b010, 5'd3);
        @(negedge clk);
        sram_rvalid = 1; sram_rdata = 64'hDEAD_BEEF_0000_0000;
        @(negedge clk);
        sram_rvalid = 0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_DEAD_BEEF || resp_rd !== 5'd3 || resp_err !== 1'b0) begin
            errors++; $display("FAIL midreset_next: valid=%b data=%h rd=%0d err=%b expected 1 ffffffffdeadbeef 3 0",
                               resp_valid, resp_data, resp_rd, resp_err);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_ld();
        test_extend();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
